signal_sequencer: RTL and testbench

Control sequencer that sits directly upstream of the control-signal ROM. On a start request it walks ROM addresses from a programmable start address, asserts the ROM read-enable, registers each returned control word, and presents it to the PE array with a valid/ready handshake for a programmable number of accepted cycles. The sequence ends on an end-of-program (EOP) bit in the word or at the last ROM address.

---
 rtl/signal_seq_pkg.sv | 33 +++
 rtl/hold_counter.sv | 36 +++
 rtl/signal_sequencer.sv | 158 +++++++++++++++
 tb/tb_signal_sequencer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/signal_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : signal_seq_pkg
// Description : Shared types and constants for the control-signal sequencer.
//               The optional multi-pass feature is enabled by the macro
//               SIGNAL_SEQ_LOOP_EN (see signal_sequencer).
// Revision    : 1.0 - initial release
// ============================================================================
package signal_seq_pkg;

   // Default widths
   localparam int DEF_MEMORY_WIDTH = 63;
   localparam int DEF_ADDRS_WIDTH  = 4;
   localparam int DEF_HOLD_WIDTH   = 8;

   // End-of-program flag is the MSB of the control word
   localparam int EOP_BIT = DEF_MEMORY_WIDTH - 1;

   // Sequencer states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2,
      DONE  = 2'd3
   } seq_state_t;

   // EOP index for a control word of arbitrary width
   function automatic int eop_index(input int width);
      return width - 1;
   endfunction

endpackage : signal_seq_pkg
`default_nettype wire

// File: rtl/hold_counter.sv
`default_nettype none
// ============================================================================
// Module      : hold_counter
// Description : Loadable down-counter with zero flag. Decrements only on an
//               enable (accepted handshake cycle) and saturates at zero.
// Revision    : 1.0 - initial release
// ============================================================================
module hold_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_clr,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_load_val,
   input  logic             i_dec,
   output logic             o_zero
);

   logic [WIDTH-1:0] r_count;

   // Load takes priority over decrement; clear (abort) over both
   always_ff @(posedge clk) begin
      if (reset || i_clr) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_dec && (r_count != '0)) begin
         r_count <= r_count - WIDTH'(1);
      end
   end

   assign o_zero = (r_count == '0);

endmodule : hold_counter
`default_nettype wire

// File: rtl/signal_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : signal_sequencer
// Description : Walks the control-signal ROM from a programmable start
//               address, registers each word and presents it to the PE array
//               for hold_cycles_i+1 accepted cycles. Ends on the EOP bit or
//               at the last ROM address.
//               Optional: define SIGNAL_SEQ_LOOP_EN to add loop_count_i,
//               giving extra passes over the same program.
// Revision    : 1.0 - initial release
// ============================================================================
module signal_sequencer
   import signal_seq_pkg::*;
#(
   parameter int MEMORY_WIDTH = DEF_MEMORY_WIDTH,
   parameter int ADDRS_WIDTH  = DEF_ADDRS_WIDTH,
   parameter int HOLD_WIDTH   = DEF_HOLD_WIDTH
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start_i,
   input  logic                    abort_i,
   input  logic [ADDRS_WIDTH-1:0]  start_addr_i,
   input  logic [HOLD_WIDTH-1:0]   hold_cycles_i,
`ifdef SIGNAL_SEQ_LOOP_EN
   input  logic [7:0]              loop_count_i,
`endif
   output logic [ADDRS_WIDTH-1:0]  addrs_rom_signal_o,
   output logic                    rd_rom_signals_ld_o,
   input  logic [MEMORY_WIDTH-1:0] rom_signals_data_i,
   output logic [MEMORY_WIDTH-1:0] signals_o,
   output logic                    signals_valid_o,
   input  logic                    signals_ready_i,
   output logic                    busy_o,
   output logic                    done_o
);

   localparam int c_EOP_BIT = eop_index(MEMORY_WIDTH);

   seq_state_t              r_state;
   logic [ADDRS_WIDTH-1:0]  r_addr;
   logic                    r_rd;
   logic                    r_valid;
   logic                    r_done;
   logic [MEMORY_WIDTH-1:0] r_signals;

   logic                    w_cnt_zero;
   logic                    w_accept;
   logic                    w_final_accept;
   logic                    w_last_word;
   logic                    w_more_passes;
   logic [ADDRS_WIDTH-1:0]  w_restart_addr;

   assign w_accept       = (r_state == HOLD) && signals_ready_i;
   assign w_last_word    = r_signals[c_EOP_BIT] || (&r_addr);
   assign w_final_accept = w_accept && w_cnt_zero && w_last_word;

`ifdef SIGNAL_SEQ_LOOP_EN
   logic [7:0]             r_passes;
   logic [ADDRS_WIDTH-1:0] r_start_addr;

   // Pass bookkeeping: captured on start, consumed at each program end
   always_ff @(posedge clk) begin
      if (reset || abort_i) begin
         r_passes     <= '0;
         r_start_addr <= '0;
      end else if ((r_state == IDLE) && start_i) begin
         r_passes     <= loop_count_i;
         r_start_addr <= start_addr_i;
      end else if (w_final_accept && (r_passes != '0)) begin
         r_passes <= r_passes - 8'd1;
      end
   end

   assign w_more_passes  = (r_passes != '0);
   assign w_restart_addr = r_start_addr;
`else
   assign w_more_passes  = 1'b0;
   assign w_restart_addr = r_addr;
`endif

   // Per-word accepted-cycle counter, loaded while the word is fetched
   hold_counter #(
      .WIDTH (HOLD_WIDTH)
   ) u_hold_counter (
      .clk        (clk),
      .reset      (reset),
      .i_clr      (abort_i),
      .i_load     ((r_state == FETCH) && !abort_i),
      .i_load_val (hold_cycles_i),
      .i_dec      (w_accept && !abort_i),
      .o_zero     (w_cnt_zero)
   );

   // Sequencer FSM with registered ROM and array-side outputs
   always_ff @(posedge clk) begin
      if (reset || abort_i) begin
         r_state   <= IDLE;
         r_addr    <= '0;
         r_rd      <= 1'b0;
         r_valid   <= 1'b0;
         r_done    <= 1'b0;
         r_signals <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               r_done <= 1'b0;
               if (start_i) begin
                  r_addr  <= start_addr_i;
                  r_rd    <= 1'b1;
                  r_state <= FETCH;
               end
            end
            FETCH: begin
               r_signals <= rom_signals_data_i;
               r_rd      <= 1'b0;
               r_valid   <= 1'b1;
               r_state   <= HOLD;
            end
            HOLD: begin
               if (w_accept && w_cnt_zero) begin
                  r_valid <= 1'b0;
                  if (w_last_word) begin
                     if (w_more_passes) begin
                        r_addr  <= w_restart_addr;
                        r_rd    <= 1'b1;
                        r_state <= FETCH;
                     end else begin
                        r_done  <= 1'b1;
                        r_state <= DONE;
                     end
                  end else begin
                     r_addr  <= r_addr + ADDRS_WIDTH'(1);
                     r_rd    <= 1'b1;
                     r_state <= FETCH;
                  end
               end
            end
            DONE: begin
               r_done  <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign addrs_rom_signal_o  = r_addr;
   assign rd_rom_signals_ld_o = r_rd;
   assign signals_o           = r_signals;
   assign signals_valid_o     = r_valid;
   assign busy_o              = (r_state != IDLE);
   assign done_o              = r_done;

endmodule : signal_sequencer
`default_nettype wire

// File: tb/tb_signal_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_signal_sequencer
// Description : Self-checking bench for signal_sequencer. A behavioural ROM
//               and a timeline model (word list from start address to EOP or
//               last address, hold+1 accepts per word, one bubble between
//               words, one done cycle) predict every output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_signal_sequencer;

   localparam int MW = 63;
   localparam int AW = 4;
   localparam int HW = 8;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start_i = 1'b0;
   logic          abort_i = 1'b0;
   logic [AW-1:0] start_addr_i = '0;
   logic [HW-1:0] hold_cycles_i = '0;
   logic [AW-1:0] addrs_rom_signal_o;
   logic          rd_rom_signals_ld_o;
   logic [MW-1:0] rom_signals_data_i;
   logic [MW-1:0] signals_o;
   logic          signals_valid_o;
   logic          signals_ready_i = 1'b0;
   logic          busy_o;
   logic          done_o;

   logic [MW-1:0] rom [16];

   int checks   = 0;
   int failures = 0;

   assign rom_signals_data_i = rom[addrs_rom_signal_o];

   always #5 clk = ~clk;

   signal_sequencer #(
      .MEMORY_WIDTH (MW),
      .ADDRS_WIDTH  (AW),
      .HOLD_WIDTH   (HW)
   ) dut (
      .clk                 (clk),
`ifdef SIGNAL_SEQ_LOOP_EN
      .loop_count_i        (8'd0),
`endif
      .reset               (reset),
      .start_i             (start_i),
      .abort_i             (abort_i),
      .start_addr_i        (start_addr_i),
      .hold_cycles_i       (hold_cycles_i),
      .addrs_rom_signal_o  (addrs_rom_signal_o),
      .rd_rom_signals_ld_o (rd_rom_signals_ld_o),
      .rom_signals_data_i  (rom_signals_data_i),
      .signals_o           (signals_o),
      .signals_valid_o     (signals_valid_o),
      .signals_ready_i     (signals_ready_i),
      .busy_o              (busy_o),
      .done_o              (done_o)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Outputs expected while the sequencer sits in IDLE after reset/abort
   task automatic chk_cleared(input string tag);
      chk({tag, "_busy"},  64'(busy_o), 64'd0);
      chk({tag, "_valid"}, 64'(signals_valid_o), 64'd0);
      chk({tag, "_rd"},    64'(rd_rom_signals_ld_o), 64'd0);
      chk({tag, "_done"},  64'(done_o), 64'd0);
      chk({tag, "_addr"},  64'(addrs_rom_signal_o), 64'd0);
      chk({tag, "_sig"},   64'(signals_o), 64'd0);
   endtask

   // One full sequence. rmode: 0 ready high, 1 toggling per word, 2 random.
   // ab_word/ab_cyc: HOLD cycle at which to abort (-1 = none); ab_rst uses reset.
   task automatic run_seq(input logic [AW-1:0] sa, input int h, input int rmode,
                          input bit noise, input int ab_word, input int ab_cyc,
                          input bit ab_rst);
      int  addrs[$];
      int  a;
      int  acc;
      int  cyc;
      bit  rdy;
      a = int'(sa);
      forever begin
         addrs.push_back(a);
         if (rom[a][MW-1] || a == 15) break;
         a++;
      end

      @(negedge clk);
      start_i       = 1'b1;
      start_addr_i  = sa;
      hold_cycles_i = HW'(h);
      signals_ready_i = 1'b0;

      for (int k = 0; k < addrs.size(); k++) begin
         @(negedge clk);
         start_i = 1'b0;
         chk("fetch_valid", 64'(signals_valid_o), 64'd0);
         chk("fetch_rd",    64'(rd_rom_signals_ld_o), 64'd1);
         chk("fetch_addr",  64'(addrs_rom_signal_o), 64'(addrs[k]));
         chk("fetch_busy",  64'(busy_o), 64'd1);
         acc = 0;
         cyc = 0;
         while (acc < h + 1) begin
            @(negedge clk);
            chk("hold_valid", 64'(signals_valid_o), 64'd1);
            chk("hold_rd",    64'(rd_rom_signals_ld_o), 64'd0);
            chk("hold_addr",  64'(addrs_rom_signal_o), 64'(addrs[k]));
            chk("hold_sig",   64'(signals_o), 64'(rom[addrs[k]]));
            chk("hold_done",  64'(done_o), 64'd0);
            case (rmode)
               0:       rdy = 1'b1;
               1:       rdy = (cyc % 2 == 0);
               default: rdy = 1'($urandom_range(1, 0));
            endcase
            signals_ready_i = rdy;
            if (k == ab_word && cyc == ab_cyc) begin
               if (ab_rst) reset = 1'b1;
               else        abort_i = 1'b1;
               @(negedge clk);
               reset   = 1'b0;
               abort_i = 1'b0;
               signals_ready_i = 1'b0;
               chk_cleared("abort");
               @(negedge clk);
               chk("abort_nodone", 64'(done_o), 64'd0);
               return;
            end
            if (noise) begin
               start_i      = 1'($urandom_range(1, 0));
               start_addr_i = AW'($urandom_range(15, 0));
            end
            if (rdy) acc++;
            cyc++;
            if (cyc > 300) begin
               checks++;
               failures++;
               $error("FAIL hold_timeout observed=%0d expected<=%0d", cyc, 300);
               return;
            end
         end
      end

      @(negedge clk);
      start_i = 1'b0;
      signals_ready_i = 1'b0;
      chk("done_pulse", 64'(done_o), 64'd1);
      chk("done_valid", 64'(signals_valid_o), 64'd0);
      chk("done_busy",  64'(busy_o), 64'd1);
      chk("done_addr",  64'(addrs_rom_signal_o), 64'(addrs[addrs.size()-1]));
      @(negedge clk);
      chk("idle_busy",  64'(busy_o), 64'd0);
      chk("idle_done",  64'(done_o), 64'd0);
      chk("idle_valid", 64'(signals_valid_o), 64'd0);
   endtask

   task automatic fill_rom(input int eop_at);
      for (int i = 0; i < 16; i++) begin
         rom[i] = MW'({$urandom(), $urandom()});
         rom[i][MW-1] = (i == eop_at);
      end
   endtask

   initial begin
      fill_rom(2);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      chk_cleared("reset");
      reset = 1'b0;
      @(negedge clk);
      chk_cleared("post_reset");

      // Three words, EOP on word 2, single accept each
      run_seq(4'd0, 0, 0, 1'b0, -1, -1, 1'b0);
      // Four accepts per word under a toggling ready
      run_seq(4'd0, 3, 1, 1'b0, -1, -1, 1'b0);
      // No EOP: stops at the last address without wrapping
      fill_rom(-1);
      run_seq(4'd14, 0, 0, 1'b0, -1, -1, 1'b0);
      run_seq(4'd14, 1, 2, 1'b0, -1, -1, 1'b0);
      run_seq(4'd15, 2, 2, 1'b0, -1, -1, 1'b0);
      // Abort in the second HOLD cycle of word 1, then a clean rerun
      fill_rom(2);
      run_seq(4'd0, 3, 1, 1'b0, 1, 1, 1'b0);
      run_seq(4'd0, 0, 0, 1'b0, -1, -1, 1'b0);
      // Start pulses while busy are ignored
      run_seq(4'd0, 0, 0, 1'b1, -1, -1, 1'b0);
      run_seq(4'd0, 2, 2, 1'b1, -1, -1, 1'b0);
      // Abort coinciding with the final accept suppresses done
      run_seq(4'd0, 0, 0, 1'b0, 2, 0, 1'b0);
      // Reset mid-sequence acts like abort
      run_seq(4'd0, 2, 2, 1'b0, 1, 2, 1'b1);
      run_seq(4'd0, 0, 0, 1'b0, -1, -1, 1'b0);

      // Randomized programs
      for (int n = 0; n < 8; n++) begin
         fill_rom(int'($urandom_range(15, 0)));
         if ($urandom_range(2, 0) == 0) rom[$urandom_range(15, 0)][MW-1] = 1'b1;
         run_seq(AW'($urandom_range(15, 0)), int'($urandom_range(3, 0)), 2,
                 1'($urandom_range(1, 0)), -1, -1, 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_signal_sequencer
`default_nettype wire
